// File: rtl/dsp_pkg.sv
// Shared DSP datapath widths so the NCO stage, the mixer and the downstream filters agree.
package dsp_pkg;

    localparam int D_WIDTH   = 12;
    localparam int NCO_WIDTH = 16;
    localparam int O_WIDTH   = 16;
    localparam int MIX_SHIFT = 11;

    // A signed a-bit by b-bit product plus one guard bit, so negating it never overflows.
    function automatic int prod_width(input int a, input int b);
        return a + b + 1;
    endfunction

endpackage

// File: rtl/iq_downmixer_if.sv
// Sample/NCO input bundle and baseband I/Q output bundle of the downmixer.
interface iq_downmixer_if #(
    parameter int D_WIDTH   = dsp_pkg::D_WIDTH,
    parameter int NCO_WIDTH = dsp_pkg::NCO_WIDTH,
    parameter int O_WIDTH   = dsp_pkg::O_WIDTH
);
    // Input beat transfers on a clock edge where s_valid & nco_valid & s_ready;
    // output beat transfers where m_valid & m_ready, and m_* stay stable until then.
    logic signed [D_WIDTH-1:0]   s_data;
    logic                        s_valid;
    logic signed [NCO_WIDTH-1:0] nco_cos;
    logic signed [NCO_WIDTH-1:0] nco_sin;
    logic                        nco_valid;
    logic                        s_ready;
    logic signed [O_WIDTH-1:0]   m_i;
    logic signed [O_WIDTH-1:0]   m_q;
    logic                        m_valid;
    logic                        m_ready;
    logic                        sat_flag;

    modport slave (
        input  s_data, s_valid, nco_cos, nco_sin, nco_valid, m_ready,
        output s_ready, m_i, m_q, m_valid, sat_flag
    );

    modport master (
        output s_data, s_valid, nco_cos, nco_sin, nco_valid, m_ready,
        input  s_ready, m_i, m_q, m_valid, sat_flag
    );

endinterface

// File: rtl/iq_downmixer_round_sat.sv
// Combinational round-half-up, arithmetic right shift and saturation of one product.
module iq_downmixer_round_sat #(
    parameter int IN_WIDTH = 29,
    parameter int SHIFT    = 11,
    parameter int O_WIDTH  = 16
) (
    input  logic signed [IN_WIDTH-1:0] din,
    output logic signed [O_WIDTH-1:0]  dout,
    output logic                       sat
);
    localparam int SW = IN_WIDTH + 1;

    localparam logic signed [SW-1:0] HALF  = {{(SW-1){1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [SW-1:0] MAX_V = {{(SW-O_WIDTH+1){1'b0}}, {(O_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_V = {{(SW-O_WIDTH+1){1'b1}}, {(O_WIDTH-1){1'b0}}};

    logic signed [SW-1:0] biased;
    logic signed [SW-1:0] shifted;

    always_comb begin
        // One extra bit keeps the rounding bias from wrapping at the positive limit.
        biased  = SW'(din) + HALF;
        shifted = biased >>> SHIFT;
        dout    = shifted[O_WIDTH-1:0];
        sat     = 1'b0;
        if (shifted > MAX_V) begin
            dout = MAX_V[O_WIDTH-1:0];
            sat  = 1'b1;
        end else if (shifted < MIN_V) begin
            dout = MIN_V[O_WIDTH-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/iq_downmixer.sv
// Three-stage real-to-complex downmixer: I = x*cos, Q = -x*sin, rounded and saturated.
module iq_downmixer #(
    parameter int D_WIDTH   = dsp_pkg::D_WIDTH,
    parameter int NCO_WIDTH = dsp_pkg::NCO_WIDTH,
    parameter int O_WIDTH   = dsp_pkg::O_WIDTH,
    parameter int SHIFT     = dsp_pkg::MIX_SHIFT
) (
    input logic           clk,
    input logic           rst,
    iq_downmixer_if.slave bus
);
    import dsp_pkg::*;

    localparam int PW = prod_width(D_WIDTH, NCO_WIDTH);

    logic en;

    logic signed [D_WIDTH-1:0]   x1_q, x1_d;
    logic signed [NCO_WIDTH-1:0] cos1_q, cos1_d;
    logic signed [NCO_WIDTH-1:0] sin1_q, sin1_d;
    logic                        v1_q, v1_d;

    logic signed [PW-1:0] pc2_q, pc2_d;
    logic signed [PW-1:0] ps2_q, ps2_d;
    logic                 v2_q, v2_d;

    logic signed [PW-1:0]      ri, rq;
    logic signed [O_WIDTH-1:0] i_sat_val, q_sat_val;
    logic                      i_sat, q_sat;

    logic signed [O_WIDTH-1:0] m_i_q, m_i_d;
    logic signed [O_WIDTH-1:0] m_q_q, m_q_d;
    logic                      m_valid_q, m_valid_d;
    logic                      sat_q, sat_d;

    // The whole pipeline moves in lockstep; it only stalls when the output is full and unread.
    assign en = ~m_valid_q | bus.m_ready;

    assign ri = pc2_q;
    assign rq = -ps2_q;

    iq_downmixer_round_sat #(
        .IN_WIDTH (PW),
        .SHIFT    (SHIFT),
        .O_WIDTH  (O_WIDTH)
    ) u_round_i (
        .din  (ri),
        .dout (i_sat_val),
        .sat  (i_sat)
    );

    iq_downmixer_round_sat #(
        .IN_WIDTH (PW),
        .SHIFT    (SHIFT),
        .O_WIDTH  (O_WIDTH)
    ) u_round_q (
        .din  (rq),
        .dout (q_sat_val),
        .sat  (q_sat)
    );

    always_comb begin
        x1_d      = x1_q;
        cos1_d    = cos1_q;
        sin1_d    = sin1_q;
        v1_d      = v1_q;
        pc2_d     = pc2_q;
        ps2_d     = ps2_q;
        v2_d      = v2_q;
        m_i_d     = m_i_q;
        m_q_d     = m_q_q;
        m_valid_d = m_valid_q;
        sat_d     = sat_q;
        if (en) begin
            x1_d      = bus.s_data;
            cos1_d    = bus.nco_cos;
            sin1_d    = bus.nco_sin;
            v1_d      = bus.s_valid & bus.nco_valid;
            pc2_d     = PW'(x1_q) * PW'(cos1_q);
            ps2_d     = PW'(x1_q) * PW'(sin1_q);
            v2_d      = v1_q;
            m_valid_d = v2_q;
            // Bubbles do not overwrite the last emitted I/Q or touch the sticky flag.
            if (v2_q) begin
                m_i_d = i_sat_val;
                m_q_d = q_sat_val;
                sat_d = sat_q | i_sat | q_sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x1_q      <= '0;
            cos1_q    <= '0;
            sin1_q    <= '0;
            v1_q      <= 1'b0;
            pc2_q     <= '0;
            ps2_q     <= '0;
            v2_q      <= 1'b0;
            m_i_q     <= '0;
            m_q_q     <= '0;
            m_valid_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            x1_q      <= x1_d;
            cos1_q    <= cos1_d;
            sin1_q    <= sin1_d;
            v1_q      <= v1_d;
            pc2_q     <= pc2_d;
            ps2_q     <= ps2_d;
            v2_q      <= v2_d;
            m_i_q     <= m_i_d;
            m_q_q     <= m_q_d;
            m_valid_q <= m_valid_d;
            sat_q     <= sat_d;
        end
    end

    assign bus.s_ready  = en;
    assign bus.m_i      = m_i_q;
    assign bus.m_q      = m_q_q;
    assign bus.m_valid  = m_valid_q;
    assign bus.sat_flag = sat_q;

endmodule

// File: tb/tb_iq_downmixer.sv
// Directed vectors, backpressure/reset sequences and random traffic against an arithmetic reference.
module tb_iq_downmixer;
    localparam int DW = 12;
    localparam int NW = 16;
    localparam int OW = 16;
    localparam int SH = 11;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    iq_downmixer_if #(.D_WIDTH(DW), .NCO_WIDTH(NW), .O_WIDTH(OW)) bus ();

    iq_downmixer #(
        .D_WIDTH   (DW),
        .NCO_WIDTH (NW),
        .O_WIDTH   (OW),
        .SHIFT     (SH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        longint x;
        longint c;
        longint s;
        longint ei;
        longint eq;
        logic   es;
    } vec_t;

    vec_t tbl[7];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [2*OW:0] exp_q[$];
    int            exp_cyc_q[$];

    logic          sat_model;
    logic          lat_check;
    logic          stall_prev;
    logic [OW-1:0] prev_i, prev_q;
    logic          ovr_en;
    logic [2*OW:0] ovr_val;
    logic          acc;
    longint        idx;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // floor((p + 2^(SH-1)) / 2^SH) with plain integer division
    function automatic longint round_floor(input longint p);
        longint n, d, q;
        d = longint'(1) << SH;
        n = p + (d / 2);
        q = n / d;
        if (n < 0 && (n % d) != 0) q = q - 1;
        return q;
    endfunction

    function automatic logic [2*OW:0] model(input longint x, input longint c, input longint s);
        longint hi, lo, ri, rq;
        logic sat;
        logic [OW-1:0] ti, tq;
        hi  = (longint'(1) << (OW - 1)) - 1;
        lo  = -(longint'(1) << (OW - 1));
        ri  = round_floor(x * c);
        rq  = round_floor(-(x * s));
        sat = 1'b0;
        if (ri > hi) begin ri = hi; sat = 1'b1; end
        if (ri < lo) begin ri = lo; sat = 1'b1; end
        if (rq > hi) begin rq = hi; sat = 1'b1; end
        if (rq < lo) begin rq = lo; sat = 1'b1; end
        ti = ri[OW-1:0];
        tq = rq[OW-1:0];
        return {sat, ti, tq};
    endfunction

    // One clock: drive at posedge+1, score at the negedge, return at the next posedge+1.
    task automatic step(input logic sv, input logic nv, input longint x, input longint c,
                        input longint s, input logic mr, input logic rs, output logic accepted);
        logic [2*OW:0] e;
        int ec;
        rst           = rs;
        bus.s_valid   = sv;
        bus.nco_valid = nv;
        bus.s_data    = DW'(x);
        bus.nco_cos   = NW'(c);
        bus.nco_sin   = NW'(s);
        bus.m_ready   = mr;
        @(negedge clk);
        accepted = sv && nv && bus.s_ready && !rs;
        if (rs) begin
            exp_q.delete();
            exp_cyc_q.delete();
            sat_model  = 1'b0;
            stall_prev = 1'b0;
        end else begin
            check("s_ready_rule", longint'(bus.s_ready), longint'(!bus.m_valid || bus.m_ready));
            if (stall_prev) begin
                check("stall_m_valid", longint'(bus.m_valid), 1);
                check("stall_m_i", longint'(bus.m_i), longint'($signed(prev_i)));
                check("stall_m_q", longint'(bus.m_q), longint'($signed(prev_q)));
            end
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_output: got m_i=%0d m_q=%0d, required no output (cycle %0d)",
                             bus.m_i, bus.m_q, cyc);
                end else begin
                    e  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    check("m_i", longint'(bus.m_i), longint'($signed(e[2*OW-1:OW])));
                    check("m_q", longint'(bus.m_q), longint'($signed(e[OW-1:0])));
                    check("sat_flag", longint'(bus.sat_flag), longint'(sat_model | e[2*OW]));
                    sat_model = sat_model | e[2*OW];
                    if (lat_check) check("latency", longint'(cyc - ec), 3);
                end
            end
            stall_prev = bus.m_valid && !bus.m_ready;
            prev_i     = bus.m_i;
            prev_q     = bus.m_q;
            if (accepted) begin
                exp_q.push_back(ovr_en ? ovr_val : model(x, c, s));
                exp_cyc_q.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0, a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{x: 1000,  c: 32767,  s: 0,      ei: 16000,  eq: 0,      es: 1'b0};
        tbl[1] = '{x: -2048, c: -32768, s: -32768, ei: 32767,  eq: -32768, es: 1'b1};
        tbl[2] = '{x: -1,    c: 1024,   s: 0,      ei: 0,      eq: 0,      es: 1'b0};
        tbl[3] = '{x: -1,    c: 1025,   s: 0,      ei: -1,     eq: 0,      es: 1'b0};
        tbl[4] = '{x: 1,     c: 0,      s: 1024,   ei: 0,      eq: 0,      es: 1'b0};
        tbl[5] = '{x: 2047,  c: 32767,  s: 32767,  ei: 32751,  eq: -32751, es: 1'b0};
        tbl[6] = '{x: -2048, c: 32767,  s: -32768, ei: -32767, eq: -32768, es: 1'b0};

        sat_model  = 1'b0;
        lat_check  = 1'b1;
        stall_prev = 1'b0;
        prev_i     = '0;
        prev_q     = '0;
        ovr_en     = 1'b0;
        ovr_val    = '0;
        rst           = 1'b1;
        bus.s_valid   = 1'b0;
        bus.nco_valid = 1'b0;
        bus.s_data    = '0;
        bus.nco_cos   = '0;
        bus.nco_sin   = '0;
        bus.m_ready   = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b1, acc);
        check("reset_m_valid", longint'(bus.m_valid), 0);
        check("reset_sat_flag", longint'(bus.sat_flag), 0);
        check("reset_m_i", longint'(bus.m_i), 0);
        check("reset_m_q", longint'(bus.m_q), 0);

        // Directed vectors, one at a time, with exact 3-cycle latency
        for (int i = 0; i < 7; i++) begin
            ovr_en  = 1'b1;
            ovr_val = {tbl[i].es, OW'(tbl[i].ei), OW'(tbl[i].eq)};
            step(1'b1, 1'b1, tbl[i].x, tbl[i].c, tbl[i].s, 1'b1, 1'b0, acc);
            ovr_en  = 1'b0;
            check("vec_accept", longint'(acc), 1);
            idle(3);
            check("vec_drained", longint'(exp_q.size()), 0);
        end
        check("sat_sticky_after_vectors", longint'(bus.sat_flag), 1);

        // Ramp 1..20 with a 5-cycle downstream stall in the middle
        lat_check = 1'b0;
        idx = 1;
        for (int k = 0; k < 80 && idx <= 20; k++) begin
            ovr_en  = 1'b1;
            ovr_val = {1'b0, OW'(idx), OW'(0)};
            step(1'b1, 1'b1, idx, 2048, 0, !(k >= 8 && k < 13), 1'b0, acc);
            if (acc) idx++;
        end
        ovr_en = 1'b0;
        idle(6);
        check("ramp_all_sent", idx, 21);
        check("ramp_drained", longint'(exp_q.size()), 0);

        // NCO not valid: nothing captured, then a single valid beat
        lat_check = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 5, 100, 100, 1'b1, 1'b0, acc);
            check("nco_invalid_m_valid", longint'(bus.m_valid), 0);
        end
        step(1'b1, 1'b1, 300, 4096, -4096, 1'b1, 1'b0, acc);
        check("nco_resume_accept", longint'(acc), 1);
        idle(3);
        check("nco_resume_drained", longint'(exp_q.size()), 0);

        // Reset with three samples in flight
        step(1'b1, 1'b1, 11, 2048, 0, 1'b1, 1'b0, acc);
        step(1'b1, 1'b1, 22, 2048, 0, 1'b1, 1'b0, acc);
        step(1'b1, 1'b1, 33, 2048, 0, 1'b1, 1'b0, acc);
        step(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1, acc);
        check("mid_reset_m_valid", longint'(bus.m_valid), 0);
        check("mid_reset_sat_flag", longint'(bus.sat_flag), 0);
        idle(4);
        step(1'b1, 1'b1, -700, 20000, 15000, 1'b1, 1'b0, acc);
        idle(3);
        check("post_reset_drained", longint'(exp_q.size()), 0);
        check("post_reset_sat_flag", longint'(bus.sat_flag), 0);

        // Random traffic with random backpressure
        lat_check = 1'b0;
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 longint'($urandom_range(0, 4095)) - 2048,
                 longint'($urandom_range(0, 65535)) - 32768,
                 longint'($urandom_range(0, 65535)) - 32768,
                 $urandom_range(0, 9) < 7, 1'b0, acc);
        end
        idle(8);
        check("random_drained", longint'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iq_downmixer.md
Name: iq_downmixer

Overview:
- Consumes the signed cos/sin pair produced by the NCO wiring stage and one real sample stream from the ADC front end.
- Produces a baseband I/Q pair: I = x*cos, Q = -x*sin, using a 3-stage pipeline.
- Applies round-half-up scaling, saturates to the output width, and supports valid/ready backpressure toward the Costas/matched-filter chain downstream.

Parameters:
- D_WIDTH, 12: signed input sample width.
- NCO_WIDTH, 16: signed cos/sin width; must match the NCO stage O_WIDTH.
- O_WIDTH, 16: signed I/Q output width.
- SHIFT, 11: arithmetic right shift applied to each product. Must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- s_data  in  D_WIDTH  signed ADC sample x.
- s_valid  in  1  sample valid.
- nco_cos  in  NCO_WIDTH  signed cosine from the NCO stage.
- nco_sin  in  NCO_WIDTH  signed sine from the NCO stage.
- nco_valid  in  1  NCO output valid.
- s_ready  out  1  block accepts an input this cycle.
- m_i  out  O_WIDTH  signed in-phase output.
- m_q  out  O_WIDTH  signed quadrature output.
- m_valid  out  1  output valid.
- m_ready  in  1  downstream accepts output.
- sat_flag  out  1  sticky: any I or Q saturation since reset.

Behaviour:
- Reset: one clock with rst=1 sets all stage valids, m_valid and sat_flag to 0 and m_i/m_q to 0. Reset mid-operation discards all in-flight data; nothing is emitted from before reset.
- Acceptance: an input is accepted when s_valid & nco_valid & s_ready. If either valid is low, nothing is captured and no bubble is counted as data.
- Pipeline enable: en = ~m_valid | m_ready, with s_ready = en (combinational).
  - When en=0 the whole pipeline holds, including valids.
  - When en=1 every stage advances; bubbles shift like data.
- Stage 1: register x, cos, sin and v1.
- Stage 2: signed products pc = x*cos and ps = x*sin, full width D_WIDTH+NCO_WIDTH+1, registered with v2.
- Stage 3:
  - Form ri = pc and rq = -ps. Negation is done in the widened width, so it never overflows.
  - Add 2^(SHIFT-1), then arithmetic-shift right by SHIFT (round half toward +inf).
  - Saturate to [-2^(O_WIDTH-1), 2^(O_WIDTH-1)-1].
  - Register m_i, m_q and m_valid = v2.
- Latency: an input accepted in cycle N appears with m_valid=1 in cycle N+3 when m_ready stays 1. Throughput is one sample per clock.
- Output holding: m_i, m_q and m_valid are held stable while m_valid & ~m_ready. No sample is lost, duplicated or reordered under any backpressure pattern.
- sat_flag: set in the cycle a saturated value is registered into stage 3; cleared only by rst.
- m_i and m_q are not forced to zero when m_valid=0; they hold their last value.

Decomposition:
- Shared package (dsp_pkg) holds the default widths D_WIDTH, NCO_WIDTH and O_WIDTH so the NCO stage, this mixer and the downstream filters agree.
- One sub-module: round_sat, combinational, parameterised IN_WIDTH/SHIFT/O_WIDTH, outputs value plus sat bit. It is instantiated twice (I and Q).

Test Plan:
- x=1000, cos=32767, sin=0, m_ready=1 -> m_i=16000, m_q=0, m_valid exactly 3 cycles after acceptance, sat_flag=0.
- x=-2048, cos=-32768, sin=-32768 -> m_i=32767 (saturated), m_q=-32768 (no saturation), sat_flag=1 and remains 1 afterward.
- Rounding: x=-1, cos=1024 -> m_i=0; x=-1, cos=1025 -> m_i=-1; x=1, sin=1024 -> m_q=0.
- Backpressure: stream ramp x=1..20 with cos=2048, sin=0, and hold m_ready=0 for 5 cycles mid-stream.
  - s_ready must drop while m_valid is held.
  - Outputs m_i=1..20 arrive in order, each exactly once, with stable values while stalled.
- nco_valid=0 with s_valid=1 for 4 cycles -> no acceptance and no m_valid. Resuming nco_valid=1 produces output 3 cycles later.
- Assert rst for 1 cycle with 3 samples in flight -> next cycle m_valid=0 and sat_flag=0. None of the 3 samples is ever emitted; a new input after reset gives the correct result at +3 cycles.
